// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and the formatters
// that feed it.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 100 MHz system clock at 115200 baud
    localparam int CLKS_PER_BIT_115200 = 868;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_DOT  = 8'h2E;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Decimal digit 0..9 to its ASCII character
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a show-ahead head: dout always presents the oldest
// entry, so a pop simply advances past it. Pop when empty and push when full
// are dropped without side effects.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes arrive over a valid/ready stream into a
// FIFO and are serialised LSB first with configurable data width, parity and
// stop bits. Frames run back-to-back; tx_enable gates only frame starts.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high, waiting for a queued byte and tx_enable
//   START  | start bit (low) for one bit time
//   DATA   | data bits LSB first, bit_idx = bit on the line
//   PARITY | parity bit captured when the byte was loaded
//   STOP   | line high for STOP_BITS bit times, may chain into START
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          tx_enable,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_cnt_n;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_n;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] sh_n;
    logic                 par_bit;
    logic                 par_bit_n;
    logic                 tx_n;
    logic                 start_frame;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 par_calc;
    logic                 bit_done;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid && s_ready),
        .pop   (fifo_pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_ready  = !fifo_full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign bit_done = (baud_cnt == BIT_LAST);
    assign par_calc = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;

    // Next-state, baud timing and next line level; tx_out is registered from tx_n
    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        sh_n        = sh;
        par_bit_n   = par_bit;
        tx_n        = tx_out;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty && tx_enable) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = sh[0];
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_n = uart_pkg::PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        sh_n      = sh >> 1;
                        tx_n      = sh[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            uart_pkg::PARITY: begin
                if (bit_done) begin
                    state_n    = STOP;
                    baud_cnt_n = '0;
                    tx_n       = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == STOP_LAST) begin
                    baud_cnt_n = '0;
                    if (!fifo_empty && tx_enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Shared frame load from IDLE or straight out of STOP
        if (start_frame) begin
            fifo_pop   = 1'b1;
            state_n    = START;
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            sh_n       = fifo_dout;
            par_bit_n  = par_calc;
            tx_n       = 1'b0;
        end
    end

    // State, timing and line registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            sh       <= sh_n;
            par_bit  <= par_bit_n;
            tx_out   <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1/16 deep, 7E2/4 deep,
// 7O1/4 deep) at 4 clocks per bit, checked every cycle against a frame-level
// reference model built from queues and whole-frame bit patterns.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [2:0] s_valid;
    logic [2:0] tx_enable;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [6:0] data_c;
    wire  [2:0] s_ready;
    wire  [2:0] tx_out;
    wire  [2:0] busy;
    wire  [4:0] cnt_a;
    wire  [2:0] cnt_b;
    wire  [2:0] cnt_c;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_8n1 (
        .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(data_a),
        .tx_enable(tx_enable[0]), .tx_out(tx_out[0]), .busy(busy[0]), .fifo_count(cnt_a));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_7e2 (
        .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(data_b),
        .tx_enable(tx_enable[1]), .tx_out(tx_out[1]), .busy(busy[1]), .fifo_count(cnt_b));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_7o1 (
        .clk(clk), .reset(reset), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(data_c),
        .tx_enable(tx_enable[2]), .tx_out(tx_out[2]), .busy(busy[2]), .fifo_count(cnt_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
            end
        end
    endtask

    function automatic int nb(input int i);
        return (i == 0) ? 8 : 7;
    endfunction

    function automatic int par(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int stp(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int flen(input int i);
        return 1 + nb(i) + ((par(i) != 0) ? 1 : 0) + stp(i);
    endfunction

    function automatic int din_of(input int i);
        return (i == 0) ? int'(data_a) : ((i == 1) ? int'(data_b) : int'(data_c));
    endfunction

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt_a) : ((i == 1) ? int'(cnt_b) : int'(cnt_c));
    endfunction

    // Whole frame as a bit pattern: start, data LSB first, parity, stop bits
    function automatic logic [15:0] frame_of(input int i, input int v);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int j = 0; j < nb(i); j++) begin
            f[1 + j] = 1'((v >> j) & 1);
            ones += (v >> j) & 1;
        end
        if (par(i) == 1) f[1 + nb(i)] = (ones % 2 == 0);
        if (par(i) == 2) f[1 + nb(i)] = (ones % 2 == 1);
        return f;
    endfunction

    // Reference model: per instance a byte queue plus the frame currently on the line
    int unsigned mq [3][$];
    bit          act [3];
    int          tt [3];
    logic [15:0] fw [3];
    int          exp_tx [3];
    int          exp_busy [3];
    int          exp_cnt [3];
    int          exp_rdy [3];

    initial begin
        int  sz;
        bit  acc;
        int  dv;
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            tt[i]  = 0;
            fw[i]  = '1;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    mq[i].delete();
                    act[i] = 1'b0;
                    tt[i]  = 0;
                end else begin
                    sz  = mq[i].size();
                    acc = s_valid[i] && (sz < dep(i));
                    dv  = din_of(i);
                    if (act[i]) begin
                        tt[i]++;
                        if (tt[i] == flen(i) * CPB) act[i] = 1'b0;
                    end
                    if (!act[i] && sz > 0 && tx_enable[i]) begin
                        fw[i]  = frame_of(i, int'(mq[i].pop_front()));
                        act[i] = 1'b1;
                        tt[i]  = 0;
                    end
                    if (acc) mq[i].push_back(dv);
                end
                exp_tx[i]   = act[i] ? int'(fw[i][tt[i] / CPB]) : 1;
                exp_cnt[i]  = mq[i].size();
                exp_busy[i] = (act[i] || mq[i].size() != 0) ? 1 : 0;
                exp_rdy[i]  = (mq[i].size() < dep(i)) ? 1 : 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tx_out[%0d]", i), int'(tx_out[i]), exp_tx[i]);
                chk($sformatf("busy[%0d]", i), int'(busy[i]), exp_busy[i]);
                chk($sformatf("fifo_count[%0d]", i), cnt_of(i), exp_cnt[i]);
                chk($sformatf("s_ready[%0d]", i), int'(s_ready[i]), exp_rdy[i]);
            end
        end
    end

    logic [7:0] burst [6];

    initial begin
        int peak;
        int j;
        burst[0] = 8'h23; burst[1] = 8'h32; burst[2] = 8'h2D;
        burst[3] = 8'h31; burst[4] = 8'h23; burst[5] = 8'h0A;
        reset     = 1'b1;
        s_valid   = 3'b000;
        tx_enable = 3'b101;
        data_a    = '0;
        data_b    = '0;
        data_c    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", int'(tx_out[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_ready", int'(s_ready[0]), 1);
        chk("rst_count", int'(cnt_a), 0);
        @(negedge clk);

        // single 8N1 byte: pop one edge after the push, line low right after
        s_valid[0] = 1'b1; data_a = 8'h23;
        @(negedge clk);
        s_valid[0] = 1'b0;
        chk("lat_count", int'(cnt_a), 1);
        chk("lat_idle_tx", int'(tx_out[0]), 1);
        @(negedge clk);
        chk("lat_start_tx", int'(tx_out[0]), 0);
        repeat (39) @(negedge clk);
        chk("stop_busy", int'(busy[0]), 1);
        @(negedge clk);
        chk("end_busy", int'(busy[0]), 0);

        // odd parity, 7 data bits: 0x35 has four ones -> parity 1
        s_valid[2] = 1'b1; data_c = 7'h35;
        @(negedge clk);
        s_valid[2] = 1'b0;
        repeat (34) @(negedge clk);
        chk("par_odd", int'(tx_out[2]), 1);
        repeat (20) @(negedge clk);

        // full FIFO with transmission held off
        for (int k = 0; k < 6; k++) begin
            s_valid[1] = 1'b1;
            data_b     = 7'($urandom_range(0, 127));
            @(negedge clk);
            if (k == 2) chk("nfull_ready", int'(s_ready[1]), 1);
            if (k == 3) chk("full_ready", int'(s_ready[1]), 0);
        end
        s_valid[1] = 1'b0;
        chk("full_count", int'(cnt_b), 4);
        chk("full_tx", int'(tx_out[1]), 1);
        repeat (5) @(negedge clk);
        tx_enable[1] = 1'b1;
        repeat (4 * 44 + 10) @(negedge clk);
        chk("full_drained", int'(cnt_b), 0);

        // even parity, two stop bits: 0x35 -> parity 0
        s_valid[1] = 1'b1; data_b = 7'h35;
        @(negedge clk);
        s_valid[1] = 1'b0;
        repeat (34) @(negedge clk);
        chk("par_even", int'(tx_out[1]), 0);
        repeat (20) @(negedge clk);

        // back-to-back burst "#2-1#\n"
        peak = 0;
        for (int k = 0; k < 6; k++) begin
            s_valid[0] = 1'b1;
            data_a     = burst[k];
            @(negedge clk);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
        end
        s_valid[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
        end
        chk("burst_peak", peak, 5);
        repeat (6 * 40) @(negedge clk);

        // tx_enable dropped during data bit 3 of the first byte
        s_valid[0] = 1'b1; data_a = 8'h31;
        @(negedge clk);
        data_a = 8'h0A;
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        tx_enable[0] = 1'b0;
        repeat (60) @(negedge clk);
        chk("hold_tx", int'(tx_out[0]), 1);
        chk("hold_count", int'(cnt_a), 1);
        chk("hold_busy", int'(busy[0]), 1);
        tx_enable[0] = 1'b1;
        repeat (50) @(negedge clk);

        // reset in the middle of a frame with three bytes queued
        for (int k = 0; k < 4; k++) begin
            s_valid[0] = 1'b1;
            data_a     = 8'h30 + 8'(k);
            @(negedge clk);
        end
        s_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rmid_tx", int'(tx_out[0]), 1);
        chk("rmid_count", int'(cnt_a), 0);
        chk("rmid_ready", int'(s_ready[0]), 1);
        chk("rmid_busy", int'(busy[0]), 0);
        s_valid[0] = 1'b1; data_a = 8'h2E;
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (50) @(negedge clk);

        // randomized traffic, enable toggling and occasional resets
        repeat (3000) begin
            s_valid = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            data_a  = 8'($urandom_range(0, 255));
            data_b  = 7'($urandom_range(0, 127));
            data_c  = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 99) == 0) begin
                j = $urandom_range(0, 2);
                tx_enable[j] = ~tx_enable[j];
            end
            reset = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        reset     = 1'b0;
        s_valid   = 3'b000;
        tx_enable = 3'b111;
        for (int k = 0; k < 2000 && busy != 3'b000; k++) @(negedge clk);
        chk("drain_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
